// File: rtl/signed_display_ctrl.sv
// signed_display_ctrl: captures an 8-bit two's-complement value, converts it to sign plus
// three BCD digits with a sequential double-dabble (one shift per clock), and scans the
// committed result onto a 4-digit common-anode seven-segment display.
// Optional build macro: SIGNED_DISPLAY_LZ_BLANK_EN enables leading-zero blanking of the
// hundreds and tens digits.
module signed_display_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

    state_t      state;
    logic [19:0] sr;          // {hund, tens, ones, mag}
    logic [19:0] adj;
    logic [2:0]  iter;
    logic        sign_work;
    logic [7:0]  mag;

    // committed display registers, only updated on commit
    logic        disp_sign;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_ones;

    logic [CW-1:0] refresh;
    logic [1:0]    index;

    logic blank_hund;
    logic blank_tens;

    assign mag = din[7] ? (~din + 8'd1) : din;
    assign dp  = 1'b1;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = sr;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
    end

    // Conversion FSM: capture, eight shift cycles, one commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            sr        <= '0;
            iter      <= '0;
            sign_work <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            disp_sign <= 1'b0;
            disp_hund <= '0;
            disp_tens <= '0;
            disp_ones <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (load) begin
                        sign_work <= din[7];
                        sr        <= {12'd0, mag};
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= StConv;
                    end
                end
                StConv: begin
                    sr   <= adj << 1;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) state <= StDone;
                end
                StDone: begin
                    disp_sign <= sign_work;
                    disp_hund <= sr[19:16];
                    disp_tens <= sr[15:12];
                    disp_ones <= sr[11:8];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of the conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh <= '0;
            index   <= '0;
        end else if (refresh == CW'(REFRESH_DIV - 1)) begin
            refresh <= '0;
            index   <= index + 2'd1;
        end else begin
            refresh <= refresh + CW'(1);
        end
    end

`ifdef SIGNED_DISPLAY_LZ_BLANK_EN
    assign blank_hund = (disp_hund == 4'd0);
    assign blank_tens = (disp_hund == 4'd0) && (disp_tens == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    // Anode and segment decode purely from registered scan index and display registers
    always_comb begin
        an  = ~(4'b0001 << index);
        seg = SEG_BLANK;
        unique case (index)
            2'd0: seg = seg_code(disp_ones);
            2'd1: seg = blank_tens ? SEG_BLANK : seg_code(disp_tens);
            2'd2: seg = blank_hund ? SEG_BLANK : seg_code(disp_hund);
            2'd3: seg = disp_sign ? SEG_MINUS : SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_signed_display_ctrl.sv
// Self-checking bench for signed_display_ctrl: scoreboard of expected display images pushed
// at load time and popped on the done pulse; arithmetic model independent of double-dabble.
module tb_signed_display_ctrl;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'd0;
    logic       load = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int fails = 0;

    logic [27:0] cur_disp;     // {idx3, idx2, idx1, idx0} segment images
    logic [27:0] sb[$];

    signed_display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .load (load),
        .busy (busy),
        .done (done),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] expect_disp(input logic [7:0] v);
        int u;
        int m;
        int h;
        int t;
        int o;
        logic [6:0] d3;
        logic [6:0] d2;
        logic [6:0] d1;
        logic [6:0] d0;
        u  = int'(v);
        m  = v[7] ? (256 - u) : u;
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        d0 = digit_seg(o);
        d1 = digit_seg(t);
        d2 = digit_seg(h);
`ifdef SIGNED_DISPLAY_LZ_BLANK_EN
        if (h == 0) d2 = 7'b1111111;
        if (h == 0 && t == 0) d1 = 7'b1111111;
`endif
        d3 = v[7] ? 7'b0111111 : 7'b1111111;
        return {d3, d2, d1, d0};
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Segment image the active digit must show; X when the anodes are not one-hot
    function automatic logic [6:0] exp_seg(input logic [27:0] disp, input logic [3:0] a);
        int i;
        i = an_index(a);
        if (i < 0) return 7'bxxxxxxx;
        return disp[i*7 +: 7];
    endfunction

    // One transaction from load at cycle N through the done pulse at N+10.
    // inject_k > 0 raises a second load at N+inject_k that must be ignored.
    task automatic run_txn(input logic [7:0] v, input int inject_k, input logic [7:0] inject_v);
        logic [27:0] exp;
        sb.push_back(expect_disp(v));
        din  = v;
        load = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            load = (k == inject_k);
            if (k == inject_k) din = inject_v;
            #1;
            if (k < 10) begin
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL txn_busy din=%h N+%0d: busy=%b done=%b, want busy=1 done=0",
                             v, k, busy, done);
                end
                tests++;
                if (seg !== exp_seg(cur_disp, an)) begin
                    fails++;
                    $display("FAIL txn_hold din=%h N+%0d an=%b: seg=%b, want %b",
                             v, k, an, seg, exp_seg(cur_disp, an));
                end
            end else begin
                tests++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    fails++;
                    $display("FAIL txn_done din=%h N+10: busy=%b done=%b, want busy=0 done=1",
                             v, busy, done);
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL txn_sb din=%h: scoreboard empty at done, want 1 entry", v);
                end else begin
                    exp = sb.pop_front();
                    if (seg !== exp_seg(exp, an)) begin
                        fails++;
                        $display("FAIL txn_commit din=%h an=%b: seg=%b, want %b",
                                 v, an, seg, exp_seg(exp, an));
                    end
                    cur_disp = exp;
                end
            end
        end
    endtask

    // Scan all four digits and compare the full image against the committed expectation
    task automatic read_display(input string name);
        logic [27:0] got;
        logic [3:0]  seen;
        int          i;
        got  = '0;
        seen = 4'b0000;
        for (int c = 0; c < 8 * DIV + 8 && seen != 4'b1111; c++) begin
            @(negedge clk);
            #1;
            i = an_index(an);
            if (i >= 0) begin
                got[i*7 +: 7] = seg;
                seen[i]       = 1'b1;
            end
        end
        tests++;
        if (seen != 4'b1111) begin
            fails++;
            $display("FAIL %s_scan: digits seen=%b, want 1111", name, seen);
        end else begin
            tests++;
            if (got !== cur_disp) begin
                fails++;
                $display("FAIL %s_image: got=%h, want %h", name, got, cur_disp);
            end
        end
    endtask

    task automatic expect_quiet(input int n, input string name);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s_quiet: done/busy activity seen, want none for %0d cycles", name, n);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_sb: %0d entries left, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst_n    = 1'b0;
        load     = 1'b0;
        din      = 8'd0;
        cur_disp = expect_disp(8'h00);
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dp !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctl: busy=%b done=%b dp=%b, want 0 0 1", busy, done, dp);
        end
        tests++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_disp: an=%b seg=%b, want 1110 1000000", an, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            exp_an = ~(4'b0001 << ((j / 4) % 4));
            tests++;
            if (an !== exp_an || seg !== exp_seg(cur_disp, exp_an)) begin
                fails++;
                $display("FAIL reset_scan j=%0d: an=%b seg=%b, want %b %b",
                         j, an, seg, exp_an, exp_seg(cur_disp, exp_an));
            end
        end
    endtask

    task automatic test_convert();
        logic [7:0] vals [6];
        vals = '{8'h85, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h63};
        foreach (vals[i]) begin
            run_txn(vals[i], 0, 8'h00);
            read_display("convert");
        end
    endtask

    task automatic test_ignored_load();
        run_txn(8'h05, 4, 8'h80);
        expect_quiet(30, "ignored");
        read_display("ignored");
    endtask

    task automatic test_reset_mid();
        run_txn(8'h85, 0, 8'h00);
        read_display("premid");
        din  = 8'h2A;
        load = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            load = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        cur_disp = expect_disp(8'h00);
        sb.delete();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_abort: busy=%b done=%b, want 0 0", busy, done);
        end
        tests++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL mid_disp: an=%b seg=%b, want 1110 1000000", an, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_quiet(30, "mid");
        read_display("mid");
    endtask

    task automatic test_back_to_back();
        run_txn(8'h0A, 0, 8'h00);
        run_txn(8'hF6, 0, 8'h00);
        read_display("b2b");
        expect_quiet(12, "b2b");
    endtask

    initial begin
        test_reset();
        test_convert();
        test_ignored_load();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
